// File: rtl/td4_run_ctrl.sv
// td4_run_ctrl - execution controller for the TD4 core.
//
// Owns the core clock enable and sequences run / halt / single-step. In RUN the core is
// paced by a prescaler (one pulse per rate+1 clocks at most). The controller stops on a PC
// breakpoint or on a jump-to-self (op 4'b1111 with im == pc, the TD4 end-of-program idiom).
//
// Optional feature (macro TD4_RUN_CTRL_CYCLE_CNT_EN): o_cycle_cnt counts issued cpu_ce
// pulses, cleared by i_cnt_clr. Without the macro o_cycle_cnt is tied to 0 and i_cnt_clr
// is ignored; the ports exist in both builds.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_cmd_run     pulse: HALT -> RUN
//   i_cmd_halt    pulse: RUN/STEP -> HALT (highest priority)
//   i_cmd_step    pulse: HALT -> STEP (one instruction)
//   i_rate        prescaler compare value, sampled live
//   i_bp_en       breakpoint enable
//   i_bp_addr     breakpoint PC
//   i_pc          core program counter
//   i_instr       core instruction at i_pc
//   o_cpu_ce      registered clock enable to the core
//   o_state       00 HALT, 01 RUN, 10 STEP
//   o_stop_bp     sticky: last stop caused by breakpoint
//   o_stop_self   sticky: last stop caused by jump-to-self
//   i_cnt_clr     clears o_cycle_cnt (feature only)
//   o_cycle_cnt   number of cpu_ce pulses issued (feature only)

module td4_run_ctrl #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_run,
    input  logic             i_cmd_halt,
    input  logic             i_cmd_step,
    input  logic [DIV_W-1:0] i_rate,
    input  logic             i_bp_en,
    input  logic [3:0]       i_bp_addr,
    input  logic [3:0]       i_pc,
    input  logic [7:0]       i_instr,
    output logic             o_cpu_ce,
    output logic [1:0]       o_state,
    output logic             o_stop_bp,
    output logic             o_stop_self,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_cycle_cnt
);

    typedef enum logic [1:0] {
        StHalt = 2'b00,
        StRun  = 2'b01,
        StStep = 2'b10
    } state_e;

    state_e           r_state;
    logic             r_cpu_ce;
    logic [DIV_W-1:0] r_cnt;
    logic             r_stop_bp;
    logic             r_stop_self;
    // Set when leaving HALT so the instruction under a breakpoint can execute once.
    logic             r_resume;

    logic w_decide;
    logic w_self;
    logic w_bp;

    // >= rather than == so a lowered rate takes effect without waiting for a wrap.
    assign w_decide = (r_cnt >= i_rate);
    assign w_self   = (i_instr[7:4] == 4'b1111) && (i_instr[3:0] == i_pc);
    assign w_bp     = i_bp_en && (i_pc == i_bp_addr) && !r_resume;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StHalt;
            r_cpu_ce    <= 1'b0;
            r_cnt       <= '0;
            r_stop_bp   <= 1'b0;
            r_stop_self <= 1'b0;
            r_resume    <= 1'b0;
        end else begin
            case (r_state)
                StHalt: begin
                    r_cpu_ce <= 1'b0;
                    if (!i_cmd_halt) begin
                        if (i_cmd_run) begin
                            r_state     <= StRun;
                            r_cnt       <= '0;
                            r_resume    <= 1'b1;
                            r_stop_bp   <= 1'b0;
                            r_stop_self <= 1'b0;
                        end else if (i_cmd_step) begin
                            r_state     <= StStep;
                            r_resume    <= 1'b1;
                            r_stop_bp   <= 1'b0;
                            r_stop_self <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    if (i_cmd_halt) begin
                        r_state  <= StHalt;
                        r_cpu_ce <= 1'b0;
                    end else if (w_decide) begin
                        r_cnt <= '0;
                        if (w_self) begin
                            r_state     <= StHalt;
                            r_stop_self <= 1'b1;
                            r_cpu_ce    <= 1'b0;
                        end else if (w_bp) begin
                            r_state   <= StHalt;
                            r_stop_bp <= 1'b1;
                            r_cpu_ce  <= 1'b0;
                        end else begin
                            r_cpu_ce <= 1'b1;
                            r_resume <= 1'b0;
                        end
                    end else begin
                        r_cnt    <= r_cnt + DIV_W'(1);
                        r_cpu_ce <= 1'b0;
                    end
                end
                StStep: begin
                    // Single unconditional pulse, then back to HALT.
                    r_state <= StHalt;
                    if (i_cmd_halt) begin
                        r_cpu_ce <= 1'b0;
                    end else begin
                        r_cpu_ce <= 1'b1;
                        r_resume <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= StHalt;
                    r_cpu_ce <= 1'b0;
                end
            endcase
        end
    end

    assign o_cpu_ce    = r_cpu_ce;
    assign o_state     = r_state;
    assign o_stop_bp   = r_stop_bp;
    assign o_stop_self = r_stop_self;

`ifdef TD4_RUN_CTRL_CYCLE_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;

    // Clear wins over a same-cycle increment; wraps naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            r_cycle_cnt <= '0;
        end else if (r_cpu_ce) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = i_cnt_clr;
    assign o_cycle_cnt      = '0;
`endif

endmodule

// File: tb/tb_td4_run_ctrl.sv
// tb_td4_run_ctrl - scoreboard bench for td4_run_ctrl.
// A reference model predicts the outputs after every clock edge and queues them; a monitor
// on the falling edge pops and compares. A tiny core model advances pc on each predicted
// cpu_ce pulse. Directed scenarios are followed by a randomized phase.

module tb_td4_run_ctrl;

`ifdef TD4_RUN_CTRL_CYCLE_CNT_EN
    localparam bit CycEn = 1'b1;
`else
    localparam bit CycEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_cmd_run = 1'b0;
    logic        i_cmd_halt = 1'b0;
    logic        i_cmd_step = 1'b0;
    logic [7:0]  i_rate = 8'd0;
    logic        i_bp_en = 1'b0;
    logic [3:0]  i_bp_addr = 4'd0;
    logic [3:0]  i_pc = 4'd0;
    logic [7:0]  i_instr = 8'd0;
    logic        i_cnt_clr = 1'b0;
    logic        o_cpu_ce;
    logic [1:0]  o_state;
    logic        o_stop_bp;
    logic        o_stop_self;
    logic [15:0] o_cycle_cnt;

    always #5 clk = ~clk;

    td4_run_ctrl #(.DIV_W(8), .CNT_W(16)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_cmd_run   (i_cmd_run),
        .i_cmd_halt  (i_cmd_halt),
        .i_cmd_step  (i_cmd_step),
        .i_rate      (i_rate),
        .i_bp_en     (i_bp_en),
        .i_bp_addr   (i_bp_addr),
        .i_pc        (i_pc),
        .i_instr     (i_instr),
        .o_cpu_ce    (o_cpu_ce),
        .o_state     (o_state),
        .o_stop_bp   (o_stop_bp),
        .o_stop_self (o_stop_self),
        .i_cnt_clr   (i_cnt_clr),
        .o_cycle_cnt (o_cycle_cnt)
    );

    typedef struct packed {
        logic        ce;
        logic [1:0]  st;
        logic        bp;
        logic        sf;
        logic [15:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: mode 0 halt, 1 run, 2 step; m_wait = clocks since last decision.
    int unsigned m_mode = 0, m_wait = 0, m_cyc = 0;
    bit          m_ce = 0, m_bp = 0, m_sf = 0, m_resume = 0;
    int unsigned n_mode, n_wait, n_cyc;
    bit          n_ce, n_bp, n_sf, n_resume;

    logic [7:0]  prog [16];
    int unsigned pc = 0;

    int pulses, step_cycles, pulses_at5;

    task automatic model_next();
        bit is_self, is_bp;
        n_mode = m_mode; n_wait = m_wait; n_cyc = m_cyc;
        n_ce = m_ce; n_bp = m_bp; n_sf = m_sf; n_resume = m_resume;
        if (i_cnt_clr) n_cyc = 0;
        else if (m_ce) n_cyc = (m_cyc + 1) % 65536;
        is_self = (i_instr[7:4] == 4'hF) && (i_instr[3:0] == i_pc);
        is_bp   = i_bp_en && (i_bp_addr == i_pc) && !m_resume;
        if (i_rst) begin
            n_mode = 0; n_wait = 0; n_cyc = 0;
            n_ce = 0; n_bp = 0; n_sf = 0; n_resume = 0;
        end else if (m_mode == 0) begin
            n_ce = 0;
            if (i_cmd_halt) begin
                // nothing to halt
            end else if (i_cmd_run) begin
                n_mode = 1; n_wait = 0; n_resume = 1; n_bp = 0; n_sf = 0;
            end else if (i_cmd_step) begin
                n_mode = 2; n_resume = 1; n_bp = 0; n_sf = 0;
            end
        end else if (m_mode == 1) begin
            if (i_cmd_halt) begin
                n_mode = 0; n_ce = 0;
            end else if (m_wait >= i_rate) begin
                n_wait = 0;
                if (is_self) begin
                    n_mode = 0; n_sf = 1; n_ce = 0;
                end else if (is_bp) begin
                    n_mode = 0; n_bp = 1; n_ce = 0;
                end else begin
                    n_ce = 1; n_resume = 0;
                end
            end else begin
                n_wait = m_wait + 1; n_ce = 0;
            end
        end else begin
            n_mode = 0;
            if (i_cmd_halt) n_ce = 0;
            else begin
                n_ce = 1; n_resume = 0;
            end
        end
    endtask

    task automatic set_pc(input int unsigned v);
        pc = v % 16;
        i_pc = 4'(pc);
        i_instr = prog[pc];
    endtask

    // One clock: predict, push after the edge, commit model, advance core, clear pulses.
    task automatic tick();
        exp_t e;
        bit   ce_now;
        ce_now = m_ce;
        model_next();
        e.ce = n_ce; e.st = 2'(n_mode); e.bp = n_bp; e.sf = n_sf;
        e.cyc = CycEn ? 16'(n_cyc) : 16'd0;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        m_mode = n_mode; m_wait = n_wait; m_cyc = n_cyc;
        m_ce = n_ce; m_bp = n_bp; m_sf = n_sf; m_resume = n_resume;
        if (ce_now) begin
            if (prog[pc][7:4] == 4'hF) set_pc(prog[pc][3:0]);
            else set_pc(pc + 1);
        end
        i_cmd_run = 1'b0; i_cmd_halt = 1'b0; i_cmd_step = 1'b0; i_cnt_clr = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if ({o_cpu_ce, o_state, o_stop_bp, o_stop_self, o_cycle_cnt} !== e) begin
                n_err++;
                $display("FAIL scoreboard: got ce=%b st=%b bp=%b sf=%b cyc=%0d, expected ce=%b st=%b bp=%b sf=%b cyc=%0d (t=%0t)",
                         o_cpu_ce, o_state, o_stop_bp, o_stop_self, o_cycle_cnt,
                         e.ce, e.st, e.bp, e.sf, e.cyc, $time);
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        set_pc(0);

        // 1: reset
        i_rst = 1'b1;
        ticks(2);
        i_rst = 1'b0;
        check("rst_state", o_state, 0);
        check("rst_ce", o_cpu_ce, 0);
        check("rst_flags", {o_stop_bp, o_stop_self}, 0);
        check("rst_cyc", o_cycle_cnt, 0);

        // 2: rate 0 run, then rate 3
        i_rate = 8'd0;
        i_cmd_run = 1'b1;
        tick();
        check("run_state", o_state, 1);
        check("run_ce_t1", o_cpu_ce, 0);
        tick();
        check("run_ce_t2", o_cpu_ce, 1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(o_cpu_ce);
        end
        check("rate0_every_cycle", pulses, 6);
        i_rate = 8'd3;
        ticks(8);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            pulses += int'(o_cpu_ce);
        end
        check("rate3_pulses", pulses, 4);

        // 3: three single steps
        i_cmd_halt = 1'b1;
        ticks(2);
        i_cnt_clr = 1'b1;
        tick();
        pulses = 0; step_cycles = 0;
        for (int s = 0; s < 3; s++) begin
            i_cmd_step = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                pulses += int'(o_cpu_ce);
                step_cycles += int'(o_state == 2'b10);
            end
        end
        check("step_pulses", pulses, 3);
        check("step_state_cycles", step_cycles, 3);
        check("step_cyc", o_cycle_cnt, CycEn ? 3 : 0);

        // 4: breakpoint at 5, then resume over it
        set_pc(0);
        i_rate = 8'd1; i_bp_en = 1'b1; i_bp_addr = 4'h5;
        i_cmd_run = 1'b1;
        pulses_at5 = 0;
        for (int i = 0; i < 60 && !(i > 0 && m_mode == 0); i++) begin
            tick();
            if (o_cpu_ce && pc == 5) pulses_at5++;
        end
        ticks(1);
        check("bp_state", o_state, 0);
        check("bp_flag", o_stop_bp, 1);
        check("bp_no_self", o_stop_self, 0);
        check("bp_pc", int'(i_pc), 5);
        check("bp_no_pulse_at5", pulses_at5, 0);
        i_cmd_run = 1'b1;
        pulses_at5 = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_cpu_ce && pc == 5) pulses_at5++;
        end
        check("bp_resume_once", pulses_at5, 1);
        check("bp_resume_running", o_state, 1);
        check("bp_flag_cleared", o_stop_bp, 0);

        // 5: jump-to-self, run+halt together, halt in RUN
        i_cmd_halt = 1'b1;
        tick();
        i_bp_en = 1'b0;
        prog[7] = 8'hF7;
        set_pc(6);
        i_cmd_run = 1'b1;
        for (int i = 0; i < 40 && !(i > 0 && m_mode == 0); i++) tick();
        ticks(1);
        check("self_state", o_state, 0);
        check("self_flag", o_stop_self, 1);
        check("self_pc", int'(i_pc), 7);
        i_cmd_run = 1'b1; i_cmd_halt = 1'b1;
        tick();
        check("run_halt_same_cycle", o_state, 0);
        check("run_halt_flag_kept", o_stop_self, 1);
        prog[7] = 8'h00;
        set_pc(0);
        i_rate = 8'd0;
        i_cmd_run = 1'b1;
        ticks(5);
        i_cmd_halt = 1'b1;
        tick();
        check("halt_ce", o_cpu_ce, 0);
        check("halt_state", o_state, 0);

        // 6: live rate change, reset mid-run
        i_rate = 8'hFF;
        i_cmd_run = 1'b1;
        ticks(50);
        i_rate = 8'd0;
        tick();
        check("rate_drop_pulse", o_cpu_ce, 1);
        ticks(3);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrun_rst_state", o_state, 0);
        check("midrun_rst_ce", o_cpu_ce, 0);

        // Random phase; one self-jump at 12 and never start from it while halted.
        prog[12] = 8'hFC;
        for (int i = 0; i < 16; i++) if (i != 12) prog[i] = 8'($urandom_range(0, 8'hEF));
        set_pc(0);
        for (int k = 0; k < 2000; k++) begin
            if (m_mode == 0 && prog[pc][7:4] == 4'hF && prog[pc][3:0] == pc[3:0]) set_pc(pc + 1);
            i_rst      = ($urandom_range(0, 199) == 0);
            i_cmd_halt = ($urandom_range(0, 24) == 0);
            i_cmd_run  = ($urandom_range(0, 9) == 0);
            i_cmd_step = ($urandom_range(0, 14) == 0);
            i_cnt_clr  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) i_rate = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) begin
                i_bp_en   = 1'($urandom_range(0, 1));
                i_bp_addr = 4'($urandom_range(0, 15));
            end
            tick();
        end
        i_rst = 1'b0;
        tick();
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
